// File: rtl/cpu_test_runner.sv
// cpu_test_runner
//   Self-checking run controller for CPUSystem. It walks a vector table of
//   NUM_TESTS entries. For each entry it loads IR, forces T to T2, waits for
//   T0 or a timeout, and then compares a masked readback against the expected
//   value.
//
//   Optional feature: TEST_RUNNER_STOP_ON_FAIL_EN
//     When defined, the run ends in DONE right after the first failing CHECK.
//
// Ports
//   Clock, Reset         clock; synchronous active-low reset
//   Start                begin a run (sampled in IDLE/DONE only)
//   Vec_Idx              index into the external vector table
//   Vec_IR/Expected/Mask combinational table data for Vec_Idx
//   IR_Load_En/Val       one-cycle IR write to CPUSystem
//   T_Force              one-cycle request to set T to T2
//   T_In                 CPU one-hot time counter
//   Check_Val            readback of the register under test
//   Busy, Done           run status
//   Pass_Count/Fail_Count, First_Fail_Idx, Timeout_Flag, Last_Cycles  results
module cpu_test_runner #(
  parameter int DATA_WIDTH = 32,
  parameter int IR_WIDTH   = 16,
  parameter int T_WIDTH    = 12,
  parameter int NUM_TESTS  = 8,
  parameter int TIMEOUT    = 64,
  localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int CNT_W = $clog2(NUM_TESTS + 1),
  localparam int LC_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  output logic [IDX_W-1:0]      Vec_Idx,
  input  logic [IR_WIDTH-1:0]   Vec_IR,
  input  logic [DATA_WIDTH-1:0] Vec_Expected,
  input  logic [DATA_WIDTH-1:0] Vec_Mask,
  output logic                  IR_Load_En,
  output logic [IR_WIDTH-1:0]   IR_Load_Val,
  output logic                  T_Force,
  input  logic [T_WIDTH-1:0]    T_In,
  input  logic [DATA_WIDTH-1:0] Check_Val,
  output logic                  Busy,
  output logic                  Done,
  output logic [CNT_W-1:0]      Pass_Count,
  output logic [CNT_W-1:0]      Fail_Count,
  output logic [IDX_W-1:0]      First_Fail_Idx,
  output logic                  Timeout_Flag,
  output logic [LC_W-1:0]       Last_Cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic             tflag_q, tflag_d;
  logic [LC_W-1:0]  last_q, last_d;
  logic [LC_W-1:0]  cyc_q, cyc_d;
  logic             to_q, to_d;
  logic             ir_en_q, ir_en_d;

  logic [LC_W-1:0]  cyc_inc;
  logic             vec_pass;
  logic             t_in_unused;

  // Only the T0 bit matters here; the rest of the one-hot counter is ignored.
  assign t_in_unused = ^T_In[T_WIDTH-1:1];

  assign cyc_inc  = cyc_q + 1'b1;
  assign vec_pass = (((Check_Val ^ Vec_Expected) & Vec_Mask) == '0) && !to_q;

  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ffi_d     = ffi_q;
    tflag_d   = tflag_q;
    last_d    = last_q;
    cyc_d     = cyc_q;
    to_d      = to_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          vec_idx_d = '0;
          pass_d    = '0;
          fail_d    = '0;
          ffi_d     = '0;
          tflag_d   = 1'b0;
          last_d    = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        cyc_d   = '0;
        to_d    = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        // T0 takes priority over a timeout landing in the same cycle.
        if (T_In[0]) begin
          to_d    = 1'b0;
          state_d = S_CHECK;
        end else if (cyc_inc == LC_W'(TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        last_d  = cyc_q;
        state_d = S_NEXT;
        if (to_q) tflag_d = 1'b1;
        if (vec_pass) begin
          if (pass_q != CNT_W'(NUM_TESTS)) pass_d = pass_q + 1'b1;
        end else begin
          if (fail_q == '0) ffi_d = vec_idx_q;
          if (fail_q != CNT_W'(NUM_TESTS)) fail_d = fail_q + 1'b1;
`ifdef TEST_RUNNER_STOP_ON_FAIL_EN
          state_d = S_DONE;
`else
          state_d = S_NEXT;
`endif
        end
      end
      S_NEXT: begin
        if (vec_idx_q == IDX_W'(NUM_TESTS - 1)) begin
          state_d = S_DONE;
        end else begin
          vec_idx_d = vec_idx_q + 1'b1;
          state_d   = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered: high exactly while the machine sits in LOAD.
    ir_en_d = (state_d == S_LOAD);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      vec_idx_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      ffi_q     <= '0;
      tflag_q   <= 1'b0;
      last_q    <= '0;
      cyc_q     <= '0;
      to_q      <= 1'b0;
      ir_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ffi_q     <= ffi_d;
      tflag_q   <= tflag_d;
      last_q    <= last_d;
      cyc_q     <= cyc_d;
      to_q      <= to_d;
      ir_en_q   <= ir_en_d;
    end
  end

  assign Vec_Idx        = vec_idx_q;
  assign IR_Load_En     = ir_en_q;
  assign T_Force        = ir_en_q;
  assign IR_Load_Val    = ir_en_q ? Vec_IR : '0;
  assign Busy           = (state_q == S_LOAD) || (state_q == S_RUN) ||
                          (state_q == S_CHECK) || (state_q == S_NEXT);
  assign Done           = (state_q == S_DONE);
  assign Pass_Count     = pass_q;
  assign Fail_Count     = fail_q;
  assign First_Fail_Idx = ffi_q;
  assign Timeout_Flag   = tflag_q;
  assign Last_Cycles    = last_q;

endmodule

// File: tb/tb_cpu_test_runner.sv
// Testbench for cpu_test_runner with NUM_TESTS=2 and TIMEOUT=8. A small CPU
// model returns T0 a programmable number of RUN cycles after T_Force. Each
// run pushes its expected summary and IR loads to queues, which are popped
// when the DUT produces IR pulses and when it reaches DONE.
module tb_cpu_test_runner;

  localparam int NT   = 2;
  localparam int TO   = 8;
  localparam int IDXW = 1;
  localparam int CNTW = 2;
  localparam int LCW  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [IDXW-1:0] vec_idx;
  logic [15:0]     vec_ir;
  logic [31:0]     vec_exp, vec_mask, check_val;
  logic            ir_en, t_force, busy, done, tflag;
  logic [15:0]     ir_val;
  logic [11:0]     t_in;
  logic [CNTW-1:0] pass_cnt, fail_cnt;
  logic [IDXW-1:0] ffi;
  logic [LCW-1:0]  last_cyc;

  logic [15:0] tb_ir [NT];
  logic [31:0] tb_ex [NT];
  logic [31:0] tb_mk [NT];
  logic [31:0] tb_cv [NT];
  int          tb_t0 [NT];   // RUN cycle in which T0 appears; 0 = never
  int          cpu_cnt = 0;

  typedef struct {
    int lat; int pass; int fail; int ffi; int tflag; int last; int idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ir_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  cpu_test_runner #(
    .DATA_WIDTH(32), .IR_WIDTH(16), .T_WIDTH(12), .NUM_TESTS(NT), .TIMEOUT(TO)
  ) dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .Vec_Idx(vec_idx),
    .Vec_IR(vec_ir), .Vec_Expected(vec_exp), .Vec_Mask(vec_mask),
    .IR_Load_En(ir_en), .IR_Load_Val(ir_val), .T_Force(t_force),
    .T_In(t_in), .Check_Val(check_val), .Busy(busy), .Done(done),
    .Pass_Count(pass_cnt), .Fail_Count(fail_cnt), .First_Fail_Idx(ffi),
    .Timeout_Flag(tflag), .Last_Cycles(last_cyc)
  );

  assign vec_ir    = tb_ir[vec_idx];
  assign vec_exp   = tb_ex[vec_idx];
  assign vec_mask  = tb_mk[vec_idx];
  assign check_val = tb_cv[vec_idx];

  // CPU model: T2 on the cycle after T_Force, T0 in RUN cycle tb_t0.
  always @(posedge clk) begin
    if (t_force) cpu_cnt <= 1;
    else if (cpu_cnt != 0 && cpu_cnt < 1000) cpu_cnt <= cpu_cnt + 1;
  end
  always_comb begin
    t_in = 12'h004;
    if (tb_t0[vec_idx] != 0 && cpu_cnt == tb_t0[vec_idx]) t_in = 12'h001;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Every IR pulse must match the next queued load and come with T_Force.
  always @(negedge clk) begin
    if (rst_n && t_force) check("ir_en_with_tforce", ir_en, 1);
    if (rst_n && ir_en) begin
      check("tforce_with_ir_en", t_force, 1);
      if (ir_q.size() == 0) check("ir_unexpected_pulse", 1, 0);
      else check("ir_load_val", ir_val, ir_q.pop_front());
    end
  end

  task automatic set_vec(input int i, input logic [15:0] ir, input logic [31:0] cv,
                         input logic [31:0] ex, input logic [31:0] mk, input int t0);
    tb_ir[i] = ir; tb_cv[i] = cv; tb_ex[i] = ex; tb_mk[i] = mk; tb_t0[i] = t0;
  endtask

  // Reference model for one complete run over the current table.
  task automatic push_expected();
    exp_t e;
    int rc;
    bit to, ok;
    e = '{lat: 1, pass: 0, fail: 0, ffi: 0, tflag: 0, last: 0, idx: 0};
    for (int i = 0; i < NT; i++) begin
      if (tb_t0[i] >= 1 && tb_t0[i] <= TO) begin rc = tb_t0[i]; to = 0; end
      else begin rc = TO; to = 1; end
      ok = !to && (((tb_cv[i] ^ tb_ex[i]) & tb_mk[i]) == 32'h0);
      ir_q.push_back(tb_ir[i]);
      e.lat += 3 + rc;
      e.last = rc;
      e.idx  = i;
      if (to) e.tflag = 1;
      if (ok) e.pass++;
      else begin
        if (e.fail == 0) e.ffi = i;
        e.fail++;
`ifdef TEST_RUNNER_STOP_ON_FAIL_EN
        e.lat -= 1;
        break;
`endif
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic run_test(input bit hold_start);
    exp_t e;
    int cycles;
    push_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cycles = 1;
    check("start_load_pulse", ir_en, 1);
    check("start_busy", busy, 1);
    check("start_pass_clr", pass_cnt, 0);
    check("start_fail_clr", fail_cnt, 0);
    check("start_tflag_clr", tflag, 0);
    check("start_idx_clr", vec_idx, 0);
    while (!done && cycles < 200) begin
      if (hold_start && cycles == 3) start = 1'b1;
      if (hold_start && cycles == 6) start = 1'b0;
      @(negedge clk); cycles++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    if (!done) begin
      check("done_within_budget", 0, 1);
    end else begin
      check("latency", cycles, e.lat);
      check("pass_count", pass_cnt, e.pass);
      check("fail_count", fail_cnt, e.fail);
      check("first_fail_idx", ffi, e.ffi);
      check("timeout_flag", tflag, e.tflag);
      check("last_cycles", last_cyc, e.last);
      check("final_idx", vec_idx, e.idx);
      check("done_not_busy", busy, 0);
      check("ir_loads_consumed", ir_q.size(), 0);
      @(negedge clk); @(negedge clk);
      check("done_hold", done, 1);
      check("done_hold_pass", pass_cnt, e.pass);
    end
    ir_q.delete();
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_ir_en"}, ir_en, 0);
    check({pfx, "_tforce"}, t_force, 0);
    check({pfx, "_ir_val"}, ir_val, 0);
    check({pfx, "_idx"}, vec_idx, 0);
    check({pfx, "_pass"}, pass_cnt, 0);
    check({pfx, "_fail"}, fail_cnt, 0);
    check({pfx, "_ffi"}, ffi, 0);
    check({pfx, "_tflag"}, tflag, 0);
    check({pfx, "_last"}, last_cyc, 0);
  endtask

  initial begin
    for (int i = 0; i < NT; i++) set_vec(i, 16'h0, 32'h0, 32'h0, 32'h0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst0");
    rst_n = 1'b1;

    // Basic pass run: 1 + 2*(3+3) = 13 cycles.
    set_vec(0, 16'hA001, 32'h1, 32'h1, 32'hFFFFFFFF, 3);
    set_vec(1, 16'hA002, 32'h1, 32'h1, 32'hFFFFFFFF, 3);
    run_test(0);

    // Masked-off low byte passes; Start held mid-run is ignored.
    set_vec(1, 16'hB002, 32'h06000a08, 32'h06000a00, 32'hFFFFFF00, 4);
    run_test(1);

    // Same vector fully masked fails at index 1.
    set_vec(1, 16'hC002, 32'h06000a08, 32'h06000a00, 32'hFFFFFFFF, 4);
    run_test(0);

    // T0 in first RUN cycle, and T0 coinciding with the timeout count.
    set_vec(0, 16'hD001, 32'h5, 32'h5, 32'hFFFFFFFF, 1);
    set_vec(1, 16'hD002, 32'h7, 32'h7, 32'hFFFFFFFF, TO);
    run_test(0);

    // Both vectors fail on data.
    set_vec(0, 16'hE001, 32'h1, 32'h2, 32'hFFFFFFFF, 2);
    set_vec(1, 16'hE002, 32'h3, 32'h4, 32'hFFFFFFFF, 2);
    run_test(0);

    // Vector 0 never reaches T0 and times out.
    set_vec(0, 16'hF001, 32'h1, 32'h1, 32'hFFFFFFFF, 0);
    set_vec(1, 16'hF002, 32'h9, 32'h9, 32'hFFFFFFFF, 2);
    run_test(0);

    // Reset in DONE clears held results.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_reset_state("rst_done");

    // Reset in the second RUN cycle of vector 0.
    set_vec(0, 16'h1111, 32'h1, 32'h1, 32'hFFFFFFFF, 3);
    set_vec(1, 16'h2222, 32'h1, 32'h1, 32'hFFFFFFFF, 3);
    ir_q.push_back(16'h1111);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;      // LOAD
    @(negedge clk);                    // RUN cycle 1
    @(negedge clk); rst_n = 1'b0;      // RUN cycle 2
    check("pre_reset_busy", busy, 1);
    @(negedge clk); rst_n = 1'b1;
    check_reset_state("rst_run");
    check("rst_run_ir_consumed", ir_q.size(), 0);
    ir_q.delete();

    // Rerun from IDLE after the aborted run.
    run_test(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_test_runner.md
# cpu_test_runner

Synthesizable self-checking run controller for the CPUSystem. It steps through a vector table of NUM_TESTS instructions. For each vector it loads the instruction into IR, forces the CPU time counter to T2, waits for the CPU to return to T0 (with a timeout), then compares a masked readback register against the expected value. It sits beside CPUSystem on the board and replaces the hand-sequenced simulation flow, so the same checks run in hardware and in any number of configurations.

## Interface
Parameters:
- DATA_WIDTH, 32, width of readback and expected values
- IR_WIDTH, 16, instruction width
- T_WIDTH, 12, width of the CPU one-hot time counter
- NUM_TESTS, 8, number of vectors, at least 1
- TIMEOUT, 64, maximum RUN cycles per vector, at least 2

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-low; one clock and a synchronous active-low reset (fixed)
- Start  in  1  begin a run; sampled only in IDLE or DONE
- Vec_Idx  out  IDX_W=max(1,$clog2(NUM_TESTS))  current vector index to the external table
- Vec_IR  in  IR_WIDTH  instruction for Vec_Idx; combinational lookup, valid in the same cycle
- Vec_Expected  in  DATA_WIDTH  expected readback for Vec_Idx
- Vec_Mask  in  DATA_WIDTH  compare mask for Vec_Idx; 1 means the bit is checked
- IR_Load_En  out  1  one-cycle IR write strobe to CPUSystem
- IR_Load_Val  out  IR_WIDTH  value to write into IR
- T_Force  out  1  one-cycle request for CPUSystem to set T = 'b100 (T2)
- T_In  in  T_WIDTH  CPU time counter as observed
- Check_Val  in  DATA_WIDTH  readback of the register under test
- Busy  out  1  high in LOAD, RUN, CHECK and NEXT
- Done  out  1  high in DONE
- Pass_Count  out  CNT_W=$clog2(NUM_TESTS+1)  vectors passed
- Fail_Count  out  CNT_W  vectors failed, including timeouts
- First_Fail_Idx  out  IDX_W  index of the first failing vector; holds 0 if none failed
- Timeout_Flag  out  1  sticky; set if any vector timed out
- Last_Cycles  out  $clog2(TIMEOUT+1)  RUN cycles taken by the most recent vector

## Operation
- States: IDLE, LOAD, RUN, CHECK, NEXT, DONE.
- Reset (Reset=0 at an edge): go to IDLE. All outputs are 0, all counters are 0 and Vec_Idx is 0. This applies from any state, including mid-RUN.
- IDLE or DONE with Start=1: clear the counters, First_Fail_Idx, Timeout_Flag and Vec_Idx, then go to LOAD. Start is ignored in every other state.
- LOAD, one cycle:
  - IR_Load_En=1, T_Force=1, IR_Load_Val=Vec_IR.
  - The cycle counter is cleared.
  - Next state is RUN.
- RUN:
  - The cycle counter increments every cycle.
  - If T_In[0]=1 (T0), go to CHECK with timeout=0.
  - Otherwise, if the count reaches TIMEOUT, go to CHECK with timeout=1.
  - If both conditions hold in the same cycle, T0 wins.
- CHECK, one cycle:
  - Pass condition: ((Check_Val ^ Vec_Expected) & Vec_Mask) == 0 and timeout=0.
  - On pass, Pass_Count increments. Otherwise Fail_Count increments.
  - On the first fail of the run, First_Fail_Idx is set to Vec_Idx.
  - On a timeout, Timeout_Flag is set.
  - Last_Cycles is set to the cycle count.
- NEXT:
  - If Vec_Idx == NUM_TESTS-1, go to DONE.
  - Otherwise, increment Vec_Idx and go to LOAD.
- DONE: Done=1. All results are held until Start or Reset.
- Counters saturate and never wrap, since they are bounded by NUM_TESTS and TIMEOUT.

## Timing
- IR_Load_En and T_Force are registered outputs, high for exactly one cycle per vector.
- The CPU sees T=T2 in the first RUN cycle. T_In[0] is therefore expected no earlier than the second RUN cycle.
- A T0 seen in the first RUN cycle is still accepted.
- Per-vector overhead outside RUN: 3 cycles (LOAD, CHECK, NEXT).
- Latency from Start to Done = 1 + sum over vectors of (3 + RUN cycles).
- Check_Val is sampled in CHECK, one cycle after T0 is observed. The CPU result register must be stable at T0.

## Configuration
- TEST_RUNNER_STOP_ON_FAIL_EN
  - Defined: after a failing CHECK, go directly to DONE. Vec_Idx holds the failing index.
  - Undefined: all NUM_TESTS vectors always run.

## Test plan
- NUM_TESTS=2, model CPU returns T0 after 3 RUN cycles, Check_Val=Vec_Expected=32'h00000001, mask all ones -> Pass_Count=2, Fail_Count=0, Done after 1+2*(3+3)=13 cycles, Last_Cycles=3.
- Vector 1 with Check_Val=32'h06000a08, Vec_Expected=32'h06000a00, mask 32'hFFFFFF00 -> pass.
- Same vector with mask 32'hFFFFFFFF -> Fail_Count=1, First_Fail_Idx=1.
- T_In never reaches T0, TIMEOUT=8 -> CHECK entered after 8 RUN cycles, Timeout_Flag=1, fail counted, run continues (stops instead if TEST_RUNNER_STOP_ON_FAIL_EN is defined).
- Reset=0 asserted in the 2nd RUN cycle of vector 0 -> next cycle in IDLE, all outputs 0. Start=1 then reruns from Vec_Idx=0.
- Start=1 held during RUN -> no effect. Start=1 in DONE -> counters cleared and a new run begins with a LOAD pulse in the next cycle.
